// File: rtl/controlador_memoria.sv
// controlador_memoria: memory subsystem for the RV32I core.
// It accepts one valid/ready request at a time, inserts LATENCIA wait
// states, applies per-byte write masks, flags misaligned and unmapped
// accesses, and exposes two memory-mapped simulation registers: an
// output port (salida) and a sticky finish flag (fin).
//
// Ports:
//   clk            clock, rising edge
//   reset          asynchronous, active-high reset
//   valido         request valid (held by the requester until listo)
//   hab_escritura  1 = write, 0 = read; sampled with valido
//   mascara[3:0]   byte write enables, bit i covers dat_escritura[8i+7:8i]
//   dir[31:0]      byte address
//   dat_escritura  write data
//   listo          one-cycle response strobe
//   dat_lectura    read data, valid while listo=1, 0 otherwise
//   error          access fault, valid while listo=1
//   salida         output register contents
//   fin            sticky finish flag
module controlador_memoria #(
    parameter int          PALABRAS   = 512,
    parameter int          LATENCIA   = 1,
    parameter string       ARCHIVO    = "",
    parameter logic [31:0] DIR_SALIDA = 32'hFFFF_FFF0,
    parameter logic [31:0] DIR_FIN    = 32'hFFFF_FFF4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        valido,
    input  logic        hab_escritura,
    input  logic [3:0]  mascara,
    input  logic [31:0] dir,
    input  logic [31:0] dat_escritura,
    output logic        listo,
    output logic [31:0] dat_lectura,
    output logic        error,
    output logic [31:0] salida,
    output logic        fin
);

    localparam int          IDX_W  = $clog2(PALABRAS);
    localparam logic [31:0] LIMITE = 32'(4 * PALABRAS);

    typedef enum logic [1:0] {REPOSO, ESPERA, RESPUESTA} estado_t;

    estado_t     estado, estado_sig;
    logic [2:0]  cuenta, cuenta_sig;
    logic        captura;     // request accepted on this edge
    logic        compromiso;  // this edge enters RESPUESTA: commit the access

    logic        we_q;
    logic [3:0]  mascara_q;
    logic [31:0] dir_q;
    logic [31:0] dat_q;

    logic [31:0] mem [PALABRAS];

    // Applies the byte enables: enabled lanes take the new data.
    function automatic logic [31:0] fusion(input logic [31:0] viejo,
                                           input logic [31:0] nuevo,
                                           input logic [3:0]  m);
        logic [31:0] r;
        r = viejo;
        for (int i = 0; i < 4; i++)
            if (m[i]) r[8*i +: 8] = nuevo[8*i +: 8];
        return r;
    endfunction

    // NOTE: every signal written here gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        estado_sig = estado;
        cuenta_sig = cuenta;
        captura    = 1'b0;
        compromiso = 1'b0;
        listo      = 1'b0;
        unique case (estado)
            REPOSO: begin
                if (valido) begin
                    captura    = 1'b1;
                    cuenta_sig = 3'(LATENCIA);
                    if (LATENCIA == 0) begin
                        estado_sig = RESPUESTA;
                        compromiso = 1'b1;
                    end else begin
                        estado_sig = ESPERA;
                    end
                end
            end
            ESPERA: begin
                if (cuenta <= 3'd1) begin
                    estado_sig = RESPUESTA;
                    compromiso = 1'b1;
                end else begin
                    cuenta_sig = cuenta - 3'd1;
                end
            end
            RESPUESTA: begin
                listo      = 1'b1;
                estado_sig = REPOSO;
            end
            default: estado_sig = REPOSO;
        endcase
    end

    // With zero wait states the commit edge is the acceptance edge, so the
    // live inputs are used; otherwise the latched request.
    logic        sel_we;
    logic [3:0]  sel_mascara;
    logic [31:0] sel_dir;
    logic [31:0] sel_dat;

    assign sel_we      = (estado == REPOSO) ? hab_escritura : we_q;
    assign sel_mascara = (estado == REPOSO) ? mascara       : mascara_q;
    assign sel_dir     = (estado == REPOSO) ? dir           : dir_q;
    assign sel_dat     = (estado == REPOSO) ? dat_escritura : dat_q;

    logic             en_ram, es_salida, es_fin, fallo;
    logic [IDX_W-1:0] idx;
    logic [31:0]      palabra_ram;
    logic [31:0]      dato_previo;

    // RAM takes priority so the MMIO words can never shadow array words.
    assign en_ram      = sel_dir < LIMITE;
    assign es_salida   = !en_ram && (sel_dir == DIR_SALIDA);
    assign es_fin      = !en_ram && !es_salida && (sel_dir == DIR_FIN);
    assign fallo       = (|sel_dir[1:0]) || !(en_ram || es_salida || es_fin);
    assign idx         = sel_dir[IDX_W+1:2];
    assign palabra_ram = mem[idx];

    always_comb begin
        dato_previo = '0;
        if (!fallo) begin
            if (en_ram)         dato_previo = palabra_ram;
            else if (es_salida) dato_previo = salida;
            else if (es_fin)    dato_previo = {31'b0, fin};
        end
    end

    // NOTE: the word array carries no reset; clearing it would force a
    // per-bit reset network and prevent block-RAM mapping.
    always_ff @(posedge clk) begin
        if (compromiso && !reset && sel_we && en_ram && !fallo)
            mem[idx] <= fusion(palabra_ram, sel_dat, sel_mascara);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado      <= REPOSO;
            cuenta      <= '0;
            we_q        <= 1'b0;
            mascara_q   <= '0;
            dir_q       <= '0;
            dat_q       <= '0;
            dat_lectura <= '0;
            error       <= 1'b0;
            salida      <= '0;
            fin         <= 1'b0;
        end else begin
            estado <= estado_sig;
            cuenta <= cuenta_sig;
            if (captura) begin
                we_q      <= hab_escritura;
                mascara_q <= mascara;
                dir_q     <= dir;
                dat_q     <= dat_escritura;
            end
            if (compromiso) begin
                dat_lectura <= dato_previo;
                error       <= fallo;
                if (sel_we && !fallo) begin
                    if (es_salida)
                        salida <= fusion(salida, sel_dat, sel_mascara);
                    // fin is sticky: only a masked-in 1 in bit 0 sets it.
                    if (es_fin && sel_mascara[0] && sel_dat[0])
                        fin <= 1'b1;
                end
            end else if (estado == RESPUESTA) begin
                dat_lectura <= '0;
                error       <= 1'b0;
            end
        end
    end

endmodule
